// File: rtl/ledger_arbiter.sv
// ledger_arbiter: round-robin front end for a shared account ledger.
// Up to N_REQ terminals issue balance / withdraw / transfer requests; one
// winner at a time is carried through IDLE -> LOAD -> EXEC -> RESP, and the
// ledger is written only at the EXEC edge, so a result seen at done is already
// committed.
module ledger_arbiter #(
  parameter int N_REQ    = 4,
  parameter int N_ACC    = 10,
  parameter int IDX_W    = 4,
  parameter int BAL_W    = 16,
  parameter int AMT_W    = 11,
  parameter int INIT_BAL = 500
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       op,
  input  logic [IDX_W*N_REQ-1:0]   src_idx,
  input  logic [IDX_W*N_REQ-1:0]   dst_idx,
  input  logic [AMT_W*N_REQ-1:0]   amount,
  output logic [N_REQ-1:0]         gnt,
  output logic                     done,
  output logic                     error,
  output logic [BAL_W-1:0]         balance_out,
  output logic                     busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0] NACC_L = (IDX_W+1)'(N_ACC);

  localparam logic [1:0] OP_BAL = 2'b00;
  localparam logic [1:0] OP_WDR = 2'b01;
  localparam logic [1:0] OP_XFR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_RESP} state_t;

  state_t              state_q;
  logic [PTR_W-1:0]    ptr_q, win_q, win_d;
  logic [1:0]          op_q;
  logic [IDX_W-1:0]    src_q, dst_q;
  logic [AMT_W-1:0]    amt_q;
  logic [BAL_W-1:0]    sbal_q, dbal_q, res_q;
  logic                err_q;
  logic [BAL_W-1:0]    ledger_q [N_ACC];
  logic [N_REQ-1:0]    gnt_q;
  logic                done_q, error_q;
  logic [BAL_W-1:0]    bal_q;

  logic                src_ok_d, dst_ok_d, funds_ok_d, err_d;
  logic [BAL_W-1:0]    amt_ext_d, src_new_d, res_d;
  logic [BAL_W:0]      dst_sum_d;

  // First requester at or after ptr, wrapping around the terminal ring.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] w;
    logic             found;
    int               idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(p) + i) % N_REQ;
      if (!found && r[idx]) begin
        w     = PTR_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] w);
    return (int'(w) == N_REQ - 1) ? '0 : w + PTR_W'(1);
  endfunction

  // Winner selection for the IDLE sample.
  always_comb begin
    win_d = rr_pick(req, ptr_q);
  end

  // EXEC evaluation: validity, funds and overflow checks on the held operands.
  always_comb begin
    src_ok_d   = ({1'b0, src_q} < NACC_L);
    dst_ok_d   = ({1'b0, dst_q} < NACC_L);
    amt_ext_d  = BAL_W'(amt_q);
    funds_ok_d = (amt_ext_d <= sbal_q);
    dst_sum_d  = {1'b0, dbal_q} + {1'b0, amt_ext_d};
    src_new_d  = sbal_q - amt_ext_d;
    case (op_q)
      OP_BAL:  err_d = !src_ok_d;
      OP_WDR:  err_d = !src_ok_d || !funds_ok_d;
      OP_XFR:  err_d = !src_ok_d || !dst_ok_d || (src_q == dst_q) ||
                       !funds_ok_d || dst_sum_d[BAL_W];
      default: err_d = 1'b1;
    endcase
    if (!src_ok_d)
      res_d = '0;
    else if (!err_d && (op_q == OP_WDR || op_q == OP_XFR))
      res_d = src_new_d;
    else
      res_d = sbal_q;
  end

  // Sequencer FSM with ledger storage and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      amt_q   <= '0;
      sbal_q  <= '0;
      dbal_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      bal_q   <= '0;
      for (int a = 0; a < N_ACC; a++) ledger_q[a] <= BAL_W'(INIT_BAL);
    end else begin
      gnt_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            win_q   <= win_d;
            op_q    <= op[int'(win_d)*2 +: 2];
            src_q   <= src_idx[int'(win_d)*IDX_W +: IDX_W];
            dst_q   <= dst_idx[int'(win_d)*IDX_W +: IDX_W];
            amt_q   <= amount[int'(win_d)*AMT_W +: AMT_W];
            ptr_q   <= ptr_after(win_d);
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          sbal_q  <= src_ok_d ? ledger_q[src_q] : '0;
          dbal_q  <= dst_ok_d ? ledger_q[dst_q] : '0;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (!err_d && op_q == OP_WDR) begin
            ledger_q[src_q] <= src_new_d;
          end else if (!err_d && op_q == OP_XFR) begin
            ledger_q[src_q] <= src_new_d;
            ledger_q[dst_q] <= dst_sum_d[BAL_W-1:0];
          end
          err_q   <= err_d;
          res_q   <= res_d;
          state_q <= S_RESP;
        end
        default: begin
          gnt_q   <= N_REQ'(1) << win_q;
          done_q  <= 1'b1;
          error_q <= err_q;
          bal_q   <= res_q;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign error       = error_q;
  assign balance_out = bal_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ledger_arbiter.sv
// Directed bench for ledger_arbiter: a default instance (INIT_BAL=500) and a
// second instance with a high initial balance to reach the dst overflow limit.
module tb_ledger_arbiter;
  localparam int N_REQ = 4;
  localparam int IDX_W = 4;
  localparam int BAL_W = 16;
  localparam int AMT_W = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N_REQ-1:0]       req  [2];
  logic [2*N_REQ-1:0]     op   [2];
  logic [IDX_W*N_REQ-1:0] src  [2];
  logic [IDX_W*N_REQ-1:0] dst  [2];
  logic [AMT_W*N_REQ-1:0] amt  [2];
  logic [N_REQ-1:0]       gnt  [2];
  logic                   done [2];
  logic                   err  [2];
  logic                   busy [2];
  logic [BAL_W-1:0]       bal  [2];

  int checks = 0;
  int failures = 0;

  ledger_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .op(op[0]), .src_idx(src[0]),
    .dst_idx(dst[0]), .amount(amt[0]), .gnt(gnt[0]), .done(done[0]),
    .error(err[0]), .balance_out(bal[0]), .busy(busy[0])
  );

  ledger_arbiter #(.INIT_BAL(61441)) u_ovf (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .op(op[1]), .src_idx(src[1]),
    .dst_idx(dst[1]), .amount(amt[1]), .gnt(gnt[1]), .done(done[1]),
    .error(err[1]), .balance_out(bal[1]), .busy(busy[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_fields(input int s, input int r, input logic [1:0] o,
                            input int sidx, input int didx, input int a);
    op[s][2*r +: 2]         = o;
    src[s][IDX_W*r +: IDX_W] = IDX_W'(sidx);
    dst[s][IDX_W*r +: IDX_W] = IDX_W'(didx);
    amt[s][AMT_W*r +: AMT_W] = AMT_W'(a);
  endtask

  task automatic wait_done(input int s, output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done[s]) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check_eq("done_timeout", 0, 1);
  endtask

  task automatic op_chk(input string tag, input int s, input int r, input logic [1:0] o,
                        input int sidx, input int didx, input int a,
                        input int exp_err, input int exp_bal);
    int lat;
    set_fields(s, r, o, sidx, didx, a);
    req[s][r] = 1'b1;
    wait_done(s, lat);
    req[s][r] = 1'b0;
    check_eq({tag, "_lat"}, lat, 4);
    check_eq({tag, "_gnt"}, gnt[s], 32'(1 << r));
    check_eq({tag, "_err"}, err[s], exp_err);
    check_eq({tag, "_bal"}, bal[s], exp_bal);
  endtask

  initial begin
    int lat;
    int last;
    int order [5];
    bit seen_done;
    order = '{0, 1, 2, 3, 0};
    for (int s = 0; s < 2; s++) begin
      req[s] = '0; op[s] = '0; src[s] = '0; dst[s] = '0; amt[s] = '0;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_gnt", gnt[0], 0);
    check_eq("rst_done", done[0], 0);
    check_eq("rst_err", err[0], 0);
    check_eq("rst_bal", bal[0], 0);
    check_eq("rst_busy", busy[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // first balance op with cycle-by-cycle busy/done tracking
    set_fields(0, 0, 2'b00, 3, 0, 0);
    req[0][0] = 1'b1;
    @(posedge clk); #1;
    check_eq("b0_busy_load", busy[0], 1);
    check_eq("b0_done_load", done[0], 0);
    @(posedge clk); #1;
    check_eq("b0_busy_exec", busy[0], 1);
    @(posedge clk); #1;
    check_eq("b0_busy_resp", busy[0], 1);
    check_eq("b0_done_resp", done[0], 0);
    @(posedge clk); #1;
    req[0][0] = 1'b0;
    check_eq("b0_done", done[0], 1);
    check_eq("b0_gnt", gnt[0], 4'b0001);
    check_eq("b0_err", err[0], 0);
    check_eq("b0_bal", bal[0], 500);
    check_eq("b0_busy_idle", busy[0], 0);
    @(posedge clk); #1;
    check_eq("b0_done_drop", done[0], 0);
    check_eq("b0_gnt_drop", gnt[0], 0);
    check_eq("b0_bal_hold", bal[0], 500);

    // withdraws
    op_chk("wd200", 0, 1, 2'b01, 2, 0, 200, 0, 300);
    op_chk("wd400", 0, 1, 2'b01, 2, 0, 400, 1, 300);
    op_chk("rd2", 0, 1, 2'b00, 2, 0, 0, 0, 300);

    // transfers and rejects
    op_chk("xf15", 0, 2, 2'b10, 1, 5, 500, 0, 0);
    op_chk("rd5", 0, 2, 2'b00, 5, 0, 0, 0, 1000);
    op_chk("xf44", 0, 2, 2'b10, 4, 4, 10, 1, 500);
    op_chk("xfdst12", 0, 2, 2'b10, 4, 12, 10, 1, 500);
    op_chk("op11", 0, 2, 2'b11, 0, 0, 5, 1, 500);
    op_chk("src11", 0, 2, 2'b00, 11, 0, 0, 1, 0);
    op_chk("wdsrc10", 0, 2, 2'b01, 10, 0, 1, 1, 0);
    op_chk("rd4", 0, 3, 2'b00, 4, 0, 0, 0, 500);

    // all four requesting: 0,1,2,3 then 0 again (req0 reasserted)
    for (int r = 0; r < N_REQ; r++) set_fields(0, r, 2'b00, r, 0, 0);
    req[0] = 4'b1111;
    last = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_done(0, lat);
      check_eq($sformatf("rr%0d_gnt", i), gnt[0], 32'(1 << order[i]));
      check_eq($sformatf("rr%0d_gap", i), cyc - last, 4);
      last = cyc;
      req[0][order[i]] = 1'b0;
      if (i == 0) begin
        @(posedge clk); #1;
        req[0][0] = 1'b1;
      end
    end

    // ptr=2 with req0 and req1 high -> 0 first
    op_chk("p2set", 0, 1, 2'b00, 0, 0, 0, 0, 500);
    req[0] = 4'b0011;
    wait_done(0, lat);
    check_eq("p2_first", gnt[0], 4'b0001);
    req[0][0] = 1'b0;
    wait_done(0, lat);
    check_eq("p2_second", gnt[0], 4'b0010);
    req[0][1] = 1'b0;

    // async reset during EXEC of a withdraw
    set_fields(0, 1, 2'b01, 6, 0, 100);
    req[0][1] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    check_eq("mid_busy_exec", busy[0], 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_busy_rst", busy[0], 0);
    req[0] = '0;
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done[0]) seen_done = 1'b1;
    end
    check_eq("mid_no_done", seen_done, 0);
    check_eq("mid_bal_clr", bal[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_fields(0, 0, 2'b00, 8, 0, 0);
    set_fields(0, 3, 2'b00, 9, 0, 0);
    req[0] = 4'b1001;
    wait_done(0, lat);
    check_eq("mid_ptr0", gnt[0], 4'b0001);
    req[0][0] = 1'b0;
    wait_done(0, lat);
    check_eq("mid_ptr_next", gnt[0], 4'b1000);
    req[0][3] = 1'b0;
    for (int a = 0; a < 10; a++)
      op_chk($sformatf("post_rd%0d", a), 0, 0, 2'b00, a, 0, 0, 0, 500);

    // destination overflow boundary on the high-balance instance
    op_chk("ov1", 1, 0, 2'b10, 0, 7, 2047, 0, 59394);
    op_chk("ov2", 1, 0, 2'b10, 0, 7, 2047, 0, 57347);
    op_chk("ov3", 1, 0, 2'b10, 0, 7, 2047, 1, 57347);
    op_chk("ov_rd7", 1, 0, 2'b00, 7, 0, 0, 0, 65535);
    op_chk("ov_rd0", 1, 0, 2'b00, 0, 0, 0, 0, 57347);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
